// File: rtl/isqrt_seq_pkg.sv
// Shared definitions for the sequential integer square-root unit:
// default widths and the FSM state encoding.
package isqrt_seq_pkg;

  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 8;
  localparam int TAG_W_DEF = 8;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_CALC_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_CALC = ST_CALC_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/isqrt_seq_if.sv
// Operand/result handshake bundle of isqrt_seq.
// The slave modport is the unit; the master modport is the producer/consumer side.
interface isqrt_seq_if import isqrt_seq_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_root;
  logic [OUT_W:0]   out_rem;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_root, out_rem, out_tag, busy
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_root, out_rem, out_tag, busy
  );

endinterface

// File: rtl/isqrt_seq_step.sv
// One restoring square-root iteration (isqrt_step): shifts two radicand bits
// into the partial remainder and decides the next root bit. Purely combinational.
module isqrt_step import isqrt_seq_pkg::*; #(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [OUT_W+1:0] rem_in,
  input  logic [OUT_W-1:0] root_in,
  input  logic [1:0]       bits,
  output logic [OUT_W+1:0] rem_out,
  output logic [OUT_W-1:0] root_out
);

  logic [OUT_W+1:0] rem_sh_s;
  logic [OUT_W+1:0] trial_s;

  // The partial remainder never exceeds 2*root, so its top two bits are zero
  // before the shift and can be dropped without loss.
  assign rem_sh_s = {rem_in[OUT_W-1:0], bits};
  assign trial_s  = {root_in, 2'b01};

  // Trial subtraction selects the next root bit.
  always_comb begin
    rem_out  = rem_sh_s;
    root_out = {root_in[OUT_W-2:0], 1'b0};
    if (rem_sh_s >= trial_s) begin
      rem_out  = rem_sh_s - trial_s;
      root_out = {root_in[OUT_W-2:0], 1'b1};
    end else begin
      rem_out  = rem_sh_s;
      root_out = {root_in[OUT_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root: one root bit per cycle, tag carried alongside.
// Define ISQRT_ROUND_EN to round out_root to nearest (out_rem stays the floor remainder).
module isqrt_seq import isqrt_seq_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  isqrt_seq_if.slave  bus
);

  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  if (((IN_W % 2) != 0) || (IN_W < 4) || (OUT_W != IN_W / 2)) begin : g_param_check
    $error("isqrt_seq: IN_W must be even and >= 4, and OUT_W must equal IN_W/2");
  end

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IN_W-1:0]  opnd_r;
  logic [OUT_W+1:0] rem_r;
  logic [OUT_W-1:0] root_r;
  logic [TAG_W-1:0] tag_r;

  logic             out_valid_r;
  logic [OUT_W-1:0] out_root_r;
  logic [OUT_W:0]   out_rem_r;
  logic [TAG_W-1:0] out_tag_r;

  logic [OUT_W+1:0] step_rem_s;
  logic [OUT_W-1:0] step_root_s;
  logic [OUT_W-1:0] final_root_s;
  logic             accept_s;

  isqrt_step #(.OUT_W(OUT_W)) u_step (
    .rem_in   (rem_r),
    .root_in  (root_r),
    .bits     (opnd_r[IN_W-1:IN_W-2]),
    .rem_out  (step_rem_s),
    .root_out (step_root_s)
  );

`ifdef ISQRT_ROUND_EN
  function automatic logic [OUT_W-1:0] round_root(input logic [OUT_W-1:0] fl,
                                                  input logic [OUT_W:0]   rm);
    logic [OUT_W-1:0] r;
    if (rm > {1'b0, fl}) begin
      if (&fl) begin
        r = fl;
      end else begin
        r = fl + {{(OUT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r = fl;
    end
    return r;
  endfunction

  // Rounded root from the final iteration, loaded into the output register on entry to DONE.
  always_comb begin
    final_root_s = round_root(step_root_s, step_rem_s[OUT_W:0]);
  end
`else
  // Floor root straight from the final iteration.
  always_comb begin
    final_root_s = step_root_s;
  end
`endif

  // A result leaving DONE frees the unit for a new operand in the same cycle.
  assign bus.in_ready = ~rst & ((state_r == ST_IDLE) |
                                ((state_r == ST_DONE) & bus.out_ready));
  assign accept_s     = bus.in_valid & bus.in_ready;

  assign bus.out_valid = out_valid_r;
  assign bus.out_root  = out_root_r;
  assign bus.out_rem   = out_rem_r;
  assign bus.out_tag   = out_tag_r;
  assign bus.busy      = (state_r != ST_IDLE);

  // Control FSM, iteration datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      opnd_r      <= {IN_W{1'b0}};
      rem_r       <= {(OUT_W+2){1'b0}};
      root_r      <= {OUT_W{1'b0}};
      tag_r       <= {TAG_W{1'b0}};
      out_valid_r <= 1'b0;
      out_root_r  <= {OUT_W{1'b0}};
      out_rem_r   <= {(OUT_W+1){1'b0}};
      out_tag_r   <= {TAG_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            opnd_r  <= bus.in_data;
            tag_r   <= bus.in_tag;
            rem_r   <= {(OUT_W+2){1'b0}};
            root_r  <= {OUT_W{1'b0}};
            cnt_r   <= CNT_W'(OUT_W - 1);
            state_r <= ST_CALC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_r  <= step_rem_s;
          root_r <= step_root_s;
          opnd_r <= {opnd_r[IN_W-3:0], 2'b00};
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            out_root_r  <= final_root_s;
            out_rem_r   <= step_rem_s[OUT_W:0];
            out_tag_r   <= tag_r;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (accept_s) begin
              opnd_r  <= bus.in_data;
              tag_r   <= bus.in_tag;
              rem_r   <= {(OUT_W+2){1'b0}};
              root_r  <= {OUT_W{1'b0}};
              cnt_r   <= CNT_W'(OUT_W - 1);
              state_r <= ST_CALC;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: directed corners, a strided sweep, backpressure,
// mid-operation reset and randomized handshaking against an arithmetic reference.
module tb_isqrt_seq;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  isqrt_seq_if bus ();

  isqrt_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Floor square root by counting up; rounding applied from the root/remainder rule.
  function automatic void ref_sqrt(input int x, output int fl, output int rm, output int rr);
    fl = 0;
    while ((fl + 1) * (fl + 1) <= x) fl++;
    rm = x - fl * fl;
    rr = fl;
`ifdef ISQRT_ROUND_EN
    if (rm > fl) rr = (fl == 255) ? 255 : fl + 1;
`endif
  endfunction

  // Drives one operand with out_ready=1; returns outputs and cycles from accept to out_valid.
  task automatic run_one(input logic [15:0] x, input logic [7:0] tg,
                         output logic [7:0] root, output logic [8:0] rem,
                         output logic [7:0] otag, output int lat);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_data   = x;
    bus.in_tag    = tg;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 50) lat = -1;
    root = bus.out_root;
    rem  = bus.out_rem;
    otag = bus.out_tag;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = 16'd0; bus.in_tag = 8'd0; bus.out_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.out_valid, bus.busy, bus.out_root, bus.out_rem, bus.out_tag} !== 27'd0)
      $display("FAIL reset_outputs: got valid=%0b busy=%0b root=%0d rem=%0d tag=%0h, want all 0",
               bus.out_valid, bus.busy, bus.out_root, bus.out_rem, bus.out_tag);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_corners();
    logic [7:0] r; logic [8:0] m; logic [7:0] t; int lat;
    run_one(16'd0, 8'hA5, r, m, t, lat);
    total_cnt++;
    if (lat !== 8) $display("FAIL zero_latency: got %0d want 8", lat); else pass_cnt++;
    total_cnt++;
    if ({r, m, t} !== {8'd0, 9'd0, 8'hA5})
      $display("FAIL zero_result: got root=%0d rem=%0d tag=%0h want 0 0 a5", r, m, t);
    else pass_cnt++;
    run_one(16'd200, 8'h11, r, m, t, lat);
    total_cnt++;
    if ({r, m, t} !== {8'd14, 9'd4, 8'h11})
      $display("FAIL op200: got root=%0d rem=%0d tag=%0h want 14 4 11", r, m, t);
    else pass_cnt++;
    run_one(16'd65535, 8'hFF, r, m, t, lat);
    total_cnt++;
    if ({r, m, t} !== {8'd255, 9'd510, 8'hFF})
      $display("FAIL op_max: got root=%0d rem=%0d tag=%0h want 255 510 ff", r, m, t);
    else pass_cnt++;
  endtask

  task automatic test_round();
    logic [7:0] r; logic [8:0] m; logic [7:0] t; int lat;
    logic [7:0] want241;
`ifdef ISQRT_ROUND_EN
    want241 = 8'd16;
`else
    want241 = 8'd15;
`endif
    run_one(16'd240, 8'h01, r, m, t, lat);
    total_cnt++;
    if ({r, m} !== {8'd15, 9'd15}) $display("FAIL round240: got root=%0d rem=%0d want 15 15", r, m);
    else pass_cnt++;
    run_one(16'd241, 8'h02, r, m, t, lat);
    total_cnt++;
    if ({r, m} !== {want241, 9'd16})
      $display("FAIL round241: got root=%0d rem=%0d want %0d 16", r, m, want241);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    logic [7:0] r; logic [8:0] m; logic [7:0] t; int lat;
    int fl, rm, rr, x;
    for (int i = 0; i < 600; i++) begin
      x = (i < 300) ? i : 300 + (i - 300) * 217;
      if (x > 65535) x = 65535 - i;
      run_one(16'(x), 8'(i), r, m, t, lat);
      ref_sqrt(x, fl, rm, rr);
      total_cnt++;
      if ({r, m, t, lat} !== {8'(rr), 9'(rm), 8'(i), 32'sd8})
        $display("FAIL sweep x=%0d: got root=%0d rem=%0d tag=%0h lat=%0d want %0d %0d %0h 8",
                 x, r, m, t, lat, rr, rm, 8'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] r0; logic [8:0] m0; logic [7:0] t0;
    logic stable_ok; int lat;
    bus.in_valid = 1'b1; bus.in_data = 16'd1000; bus.in_tag = 8'hC3; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    r0 = bus.out_root; m0 = bus.out_rem; t0 = bus.out_tag;
    total_cnt++;
    if ({lat, r0, m0, t0} !== {32'sd8, 8'd31, 9'd39, 8'hC3})
      $display("FAIL bp_result: got lat=%0d root=%0d rem=%0d tag=%0h want 8 31 39 c3", lat, r0, m0, t0);
    else pass_cnt++;
    stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.out_root, bus.out_rem, bus.out_tag} !== {r0, m0, t0}) stable_ok = 1'b0;
    end
    total_cnt++;
    if (stable_ok !== 1'b1) $display("FAIL bp_hold: got stable=%0b want 1", stable_ok);
    else pass_cnt++;
    bus.in_valid = 1'b1; bus.in_data = 16'd81; bus.in_tag = 8'h3C; bus.out_ready = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total_cnt++;
    if ({bus.out_valid, bus.busy} !== 2'b01)
      $display("FAIL bp_same_cycle_accept: got valid=%0b busy=%0b want 0 1", bus.out_valid, bus.busy);
    else pass_cnt++;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    total_cnt++;
    if ({lat, bus.out_root, bus.out_rem, bus.out_tag} !== {32'sd8, 8'd9, 9'd0, 8'h3C})
      $display("FAIL bp_next: got lat=%0d root=%0d rem=%0d tag=%0h want 8 9 0 3c",
               lat, bus.out_root, bus.out_rem, bus.out_tag);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r; logic [8:0] m; logic [7:0] t; int lat;
    run_one(16'd10000, 8'h44, r, m, t, lat);
    bus.in_valid = 1'b1; bus.in_data = 16'd50000; bus.in_tag = 8'h77; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.out_valid, bus.busy, bus.out_root, bus.out_rem, bus.out_tag} !== 27'd0)
      $display("FAIL midreset_outputs: got valid=%0b busy=%0b root=%0d rem=%0d tag=%0h want all 0",
               bus.out_valid, bus.busy, bus.out_root, bus.out_rem, bus.out_tag);
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
    run_one(16'd81, 8'h5A, r, m, t, lat);
    total_cnt++;
    if ({lat, r, m, t} !== {32'sd8, 8'd9, 9'd0, 8'h5A})
      $display("FAIL midreset_next: got lat=%0d root=%0d rem=%0d tag=%0h want 8 9 0 5a", lat, r, m, t);
    else pass_cnt++;
  endtask

  task automatic test_random();
    localparam int N = 1500;
    logic [24:0] exp_q[$];
    logic [24:0] exp_v;
    logic acc, dlv;
    logic [7:0] cr; logic [8:0] cm; logic [7:0] ct;
    int sent, got, cyc, fl, rm, rr, bad;
    sent = 0; got = 0; cyc = 0; bad = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    while (got < N && cyc < 60000) begin
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      dlv = bus.out_valid & bus.out_ready;
      cr = bus.out_root; cm = bus.out_rem; ct = bus.out_tag;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        ref_sqrt(int'(bus.in_data), fl, rm, rr);
        exp_q.push_back({8'(rr), 9'(rm), bus.in_tag});
        sent++;
      end
      if (dlv) begin
        got++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h1FFFFFF;
        total_cnt++;
        if ({cr, cm, ct} !== exp_v) begin
          bad++;
          if (bad <= 10)
            $display("FAIL random_result #%0d: got root=%0d rem=%0d tag=%0h want root=%0d rem=%0d tag=%0h",
                     got, cr, cm, ct, exp_v[24:17], exp_v[16:8], exp_v[7:0]);
        end else pass_cnt++;
      end
      if (acc || !bus.in_valid) begin
        bus.in_valid = (sent < N) && ($urandom_range(3, 0) != 0);
        case ($urandom_range(7, 0))
          0:       bus.in_data = 16'd0;
          1:       bus.in_data = 16'hFFFF;
          default: bus.in_data = 16'($urandom);
        endcase
        bus.in_tag = 8'($urandom);
      end
      bus.out_ready = ($urandom_range(1, 0) == 1);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    total_cnt++;
    if (got !== N || exp_q.size() !== 0)
      $display("FAIL random_count: got delivered=%0d pending=%0d want %0d 0", got, exp_q.size(), N);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 1'b0;
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_corners();
    test_round();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
